// File: rtl/panda_risc_v_muldiv_res_arb.sv
// rtl/panda_risc_v_muldiv_res_arb.sv - round-robin merge of mul/div results into one writeback stream
//
// Purpose:
//   Sits directly downstream of the multi-cycle multiplier and the divider.
//   Grants one of the two result streams per cycle (round-robin on contention),
//   holds granted results in a 2-entry register FIFO and presents the head entry
//   on the writeback port. Results targeting x0 can be swallowed without using a
//   buffer slot. A bitmap of destination registers still waiting in the buffer is
//   exported for issue-stage hazard checks.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   s_mul_res_*            multiplier result stream (data, rd_id, inst_id, valid/ready)
//   s_div_res_*            divider result stream (data, rd_id, inst_id, valid/ready)
//   m_wb_*                 writeback stream; m_wb_src = 0 for mul, 1 for div
//   pend_rd_bitmap         bit i set while a buffered entry targets rd i (bit 0 always 0)

module panda_risc_v_muldiv_res_arb #(
  parameter int inst_id_width    = 4,
  parameter     en_drop_x0       = "true",
  parameter int simulation_delay = 1
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [31:0]              s_mul_res_data,
  input  logic [4:0]               s_mul_res_rd_id,
  input  logic [inst_id_width-1:0] s_mul_res_inst_id,
  input  logic                     s_mul_res_valid,
  output logic                     s_mul_res_ready,

  input  logic [31:0]              s_div_res_data,
  input  logic [4:0]               s_div_res_rd_id,
  input  logic [inst_id_width-1:0] s_div_res_inst_id,
  input  logic                     s_div_res_valid,
  output logic                     s_div_res_ready,

  output logic [31:0]              m_wb_data,
  output logic [4:0]               m_wb_rd_id,
  output logic [inst_id_width-1:0] m_wb_inst_id,
  output logic                     m_wb_src,
  output logic                     m_wb_valid,
  input  logic                     m_wb_ready,

  output logic [31:0]              pend_rd_bitmap
);

  localparam logic drop_en = (en_drop_x0 == "true");

  // Register updates are zero-delay; simulation_delay is accepted so that
  // instantiations overriding it still elaborate.
  logic [31:0] unused_sim_delay;
  assign unused_sim_delay = simulation_delay;

  // Buffer storage, indexed by wr_ptr/rd_ptr.
  logic [31:0]              buf_data [2];
  logic [4:0]               buf_rd   [2];
  logic [inst_id_width-1:0] buf_id   [2];
  logic                     buf_src  [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       prio;       // 0: mul wins contention, 1: div wins

  logic       buf_full_n;
  logic       grant_mul;
  logic       grant_div;
  logic       drop_mul;
  logic       drop_div;
  logic       hs_mul;
  logic       hs_div;
  logic       push;
  logic       pop;
  logic [1:0] entry_valid;

  // Only registered state feeds the input readies, so m_wb_ready never reaches
  // s_*_ready combinationally; a pop while full frees the slot one cycle later.
  assign buf_full_n = (count != 2'd2);

  assign grant_mul = s_mul_res_valid & (~s_div_res_valid | ~prio);
  assign grant_div = s_div_res_valid & ~grant_mul;

  assign drop_mul = drop_en & (s_mul_res_rd_id == 5'd0);
  assign drop_div = drop_en & (s_div_res_rd_id == 5'd0);

  // Dropped results need no buffer slot, so they are accepted even when full.
  assign s_mul_res_ready = grant_mul & (buf_full_n | drop_mul);
  assign s_div_res_ready = grant_div & (buf_full_n | drop_div);

  assign hs_mul = s_mul_res_valid & s_mul_res_ready;
  assign hs_div = s_div_res_valid & s_div_res_ready;

  assign push = (hs_mul & ~drop_mul) | (hs_div & ~drop_div);
  assign pop  = m_wb_valid & m_wb_ready;

  assign m_wb_valid   = (count != 2'd0);
  assign m_wb_data    = buf_data[rd_ptr];
  assign m_wb_rd_id   = buf_rd[rd_ptr];
  assign m_wb_inst_id = buf_id[rd_ptr];
  assign m_wb_src     = buf_src[rd_ptr];

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      prio   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;

      if (push & ~pop)
        count <= count + 2'd1;
      else if (pop & ~push)
        count <= count - 2'd1;

      if (hs_mul)
        prio <= 1'b1;
      else if (hs_div)
        prio <= 1'b0;
    end
  end

  // Payload storage needs no reset; count gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_src[wr_ptr]  <= hs_div;
      buf_data[wr_ptr] <= hs_div ? s_div_res_data    : s_mul_res_data;
      buf_rd[wr_ptr]   <= hs_div ? s_div_res_rd_id   : s_mul_res_rd_id;
      buf_id[wr_ptr]   <= hs_div ? s_div_res_inst_id : s_mul_res_inst_id;
    end
  end

  // With one entry the valid slot is the one at rd_ptr; with two both are valid.
  always_comb begin
    entry_valid    = 2'b00;
    entry_valid[0] = (count == 2'd2) | ((count == 2'd1) & ~rd_ptr);
    entry_valid[1] = (count == 2'd2) | ((count == 2'd1) &  rd_ptr);
  end

  always_comb begin
    pend_rd_bitmap = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (entry_valid[i])
        pend_rd_bitmap[buf_rd[i]] = 1'b1;
    end
    // x0 is never a real hazard, even when x0 results are forwarded.
    pend_rd_bitmap[0] = 1'b0;
  end

endmodule

// File: tb/tb_panda_risc_v_muldiv_res_arb.sv
// tb/tb_panda_risc_v_muldiv_res_arb.sv - self-checking bench for panda_risc_v_muldiv_res_arb

module tb_panda_risc_v_muldiv_res_arb;

  logic        clk;
  logic        rst;
  logic [31:0] s_mul_res_data;
  logic [4:0]  s_mul_res_rd_id;
  logic [3:0]  s_mul_res_inst_id;
  logic        s_mul_res_valid;
  logic        s_mul_res_ready;
  logic [31:0] s_div_res_data;
  logic [4:0]  s_div_res_rd_id;
  logic [3:0]  s_div_res_inst_id;
  logic        s_div_res_valid;
  logic        s_div_res_ready;
  logic [31:0] m_wb_data;
  logic [4:0]  m_wb_rd_id;
  logic [3:0]  m_wb_inst_id;
  logic        m_wb_src;
  logic        m_wb_valid;
  logic        m_wb_ready;
  logic [31:0] pend_rd_bitmap;

  int checks;
  int failures;

  panda_risc_v_muldiv_res_arb #(
    .inst_id_width(4),
    .en_drop_x0("true"),
    .simulation_delay(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_mul_res_data(s_mul_res_data),
    .s_mul_res_rd_id(s_mul_res_rd_id),
    .s_mul_res_inst_id(s_mul_res_inst_id),
    .s_mul_res_valid(s_mul_res_valid),
    .s_mul_res_ready(s_mul_res_ready),
    .s_div_res_data(s_div_res_data),
    .s_div_res_rd_id(s_div_res_rd_id),
    .s_div_res_inst_id(s_div_res_inst_id),
    .s_div_res_valid(s_div_res_valid),
    .s_div_res_ready(s_div_res_ready),
    .m_wb_data(m_wb_data),
    .m_wb_rd_id(m_wb_rd_id),
    .m_wb_inst_id(m_wb_inst_id),
    .m_wb_src(m_wb_src),
    .m_wb_valid(m_wb_valid),
    .m_wb_ready(m_wb_ready),
    .pend_rd_bitmap(pend_rd_bitmap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic        mv;
    logic [4:0]  mrd;
    logic        dv;
    logic [4:0]  drd;
    logic        wr;
    logic        emr;
    logic        edr;
    logic        ewv;
    logic        esrc;
    logic [31:0] ebm;
  } vec_t;

  wb_t  sb[$];
  vec_t vecs[$];

  // Payload is a function of (source, rd) so a stalled source holds it naturally.
  function automatic logic [31:0] pdata(input logic src, input logic [4:0] rd);
    return (src ? 32'hD1D1_0000 : 32'h1234_5600) ^ {27'd0, rd};
  endfunction

  function automatic logic [3:0] pid(input logic src, input logic [4:0] rd);
    return rd[3:0] ^ {src, 3'b000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic dv,
                       input logic [4:0] drd, input logic wr);
    s_mul_res_valid   = mv;
    s_mul_res_rd_id   = mrd;
    s_mul_res_data    = pdata(1'b0, mrd);
    s_mul_res_inst_id = pid(1'b0, mrd);
    s_div_res_valid   = dv;
    s_div_res_rd_id   = drd;
    s_div_res_data    = pdata(1'b1, drd);
    s_div_res_inst_id = pid(1'b1, drd);
    m_wb_ready        = wr;
  endtask

  task automatic add(input logic mv, input logic [4:0] mrd, input logic dv, input logic [4:0] drd,
                     input logic wr, input logic emr, input logic edr, input logic ewv,
                     input logic esrc, input logic [31:0] ebm);
    vec_t v;
    v.mv = mv; v.mrd = mrd; v.dv = dv; v.drd = drd; v.wr = wr;
    v.emr = emr; v.edr = edr; v.ewv = ewv; v.esrc = esrc; v.ebm = ebm;
    vecs.push_back(v);
  endtask

  // Called mid-cycle: compare any pop against the queue head, then record any
  // accepted non-x0 result as the next expected writeback.
  task automatic sb_sample();
    wb_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (m_wb_valid && m_wb_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_data", m_wb_data, e.data);
          chk("sb_rd", {27'd0, m_wb_rd_id}, {27'd0, e.rd});
          chk("sb_id", {28'd0, m_wb_inst_id}, {28'd0, e.id});
          chk("sb_src", {31'd0, m_wb_src}, {31'd0, e.src});
        end
      end
      if (s_mul_res_valid && s_mul_res_ready && s_mul_res_rd_id != 5'd0) begin
        e.src = 1'b0; e.rd = s_mul_res_rd_id; e.id = s_mul_res_inst_id; e.data = s_mul_res_data;
        sb.push_back(e);
      end
      if (s_div_res_valid && s_div_res_ready && s_div_res_rd_id != 5'd0) begin
        e.src = 1'b1; e.rd = s_div_res_rd_id; e.id = s_div_res_inst_id; e.data = s_div_res_data;
        sb.push_back(e);
      end
    end
  endtask

  task automatic end_cycle();
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

    // Contention from reset: mul first, then alternating.
    //   mv    mrd    dv    drd    wr    emr   edr   ewv   esrc  ebm
    add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2);
    add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4);
    add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // Single mul, one-cycle latency into an empty buffer.
    add(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // Backpressure: rd7, rd8 fill the buffer, rd9 stalls until a slot frees.
    add(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80);
    add(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h180);
    add(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h180);
    add(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
    // x0 drop while full: accepted, bitmap unchanged, prio flips to mul.
    add(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300);
    add(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300);
    add(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // Two entries with the same rd share one bitmap bit until both leave.
    add(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8);
    add(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset then idle.
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_wb_valid", c), {31'd0, m_wb_valid}, 32'd0);
      chk($sformatf("rst%0d_bitmap", c), pend_rd_bitmap, 32'd0);
      chk($sformatf("rst%0d_mul_ready", c), {31'd0, s_mul_res_ready}, 32'd0);
      chk($sformatf("rst%0d_div_ready", c), {31'd0, s_div_res_ready}, 32'd0);
      end_cycle();
    end
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mv, vecs[i].mrd, vecs[i].dv, vecs[i].drd, vecs[i].wr);
      @(negedge clk);
      chk($sformatf("v%0d_mul_ready", i), {31'd0, s_mul_res_ready}, {31'd0, vecs[i].emr});
      chk($sformatf("v%0d_div_ready", i), {31'd0, s_div_res_ready}, {31'd0, vecs[i].edr});
      chk($sformatf("v%0d_wb_valid", i), {31'd0, m_wb_valid}, {31'd0, vecs[i].ewv});
      chk($sformatf("v%0d_bitmap", i), pend_rd_bitmap, vecs[i].ebm);
      if (vecs[i].ewv)
        chk($sformatf("v%0d_wb_src", i), {31'd0, m_wb_src}, {31'd0, vecs[i].esrc});
      end_cycle();
    end
    chk("sb_empty_after_table", sb.size(), 32'd0);

    // Reset mid-operation with two buffered entries.
    drive(1'b1, 5'd10, 1'b0, 5'd0, 1'b0);
    @(negedge clk); end_cycle();
    drive(1'b1, 5'd11, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("mid_full_bitmap_pre", pend_rd_bitmap, 32'h400);
    end_cycle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("mid_full_bitmap", pend_rd_bitmap, 32'hC00);
    end_cycle();
    rst = 1'b1;
    @(negedge clk); end_cycle();
    rst = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0);
    @(negedge clk);
    chk("post_rst_wb_valid", {31'd0, m_wb_valid}, 32'd0);
    chk("post_rst_bitmap", pend_rd_bitmap, 32'd0);
    chk("post_rst_mul_ready", {31'd0, s_mul_res_ready}, 32'd1);
    chk("post_rst_div_ready", {31'd0, s_div_res_ready}, 32'd0);
    end_cycle();

    // Drain with a bounded budget.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(negedge clk);
      end_cycle();
    end
    chk("sb_empty_final", sb.size(), 32'd0);
    @(negedge clk);
    chk("final_wb_valid", {31'd0, m_wb_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
